// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the OV7670 register-init sequencer.
package cam_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_SEND,
        ST_WAIT,
        ST_DELAY,
        ST_DONE
    } cfg_state_e;

    // ROM words with special meaning; every other word is {reg, val}.
    localparam logic [15:0] CFG_DELAY_WORD = 16'hFFF0;
    localparam logic [15:0] CFG_END_WORD   = 16'hFFFF;

    // Number of clock cycles in a delay of 'ms' milliseconds at 'clk_f' Hz.
    function automatic int unsigned ms_to_cycles(input int unsigned clk_f,
                                                 input int unsigned ms);
        return clk_f / 1000 * ms;
    endfunction

endpackage

// File: rtl/cam_delay_timer.sv
// Loadable down-counter; zero_o is high whenever the count has reached 0.
module cam_delay_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // Load takes priority; otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cam_config.sv
// OV7670 bring-up sequencer: walks the registered init ROM and issues one
// SCCB register write per entry, honouring delay and end-of-table markers.
module cam_config
    import cam_cfg_pkg::*;
#(
    parameter int unsigned CLK_F    = 25_000_000,
    parameter int unsigned DELAY_MS = 10,
    parameter int unsigned ADDR_W   = 8
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    input  logic              i_sccb_ready,
    output logic              o_sccb_start,
    output logic [7:0]        o_sccb_addr,
    output logic [7:0]        o_sccb_data,
    output logic              o_busy,
    output logic              o_done
);

    localparam int unsigned       DELAY_TOTAL = ms_to_cycles(CLK_F, DELAY_MS);
    localparam int unsigned       TMR_W       = (DELAY_TOTAL > 1) ? $clog2(DELAY_TOTAL) : 1;
    // The DELAY state spends load value + 1 cycles, hence the -1.
    localparam logic [TMR_W-1:0]  DELAY_CYC   = TMR_W'(DELAY_TOTAL - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST   = {ADDR_W{1'b1}};

    cfg_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        saddr_q, saddr_d;
    logic [7:0]        sdata_q, sdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fetch_q, fetch_d;      // high in the second FETCH cycle
    logic              wfirst_q, wfirst_d;    // high in the first WAIT cycle
    logic              tmr_load, tmr_zero;
    logic              sccb_start;
    logic              advance;

    cam_delay_timer #(
        .WIDTH(TMR_W)
    ) u_delay (
        .clk_i  (i_clk),
        .rst_ni (i_rstn),
        .load_i (tmr_load),
        .value_i(DELAY_CYC),
        .zero_o (tmr_zero)
    );

    // Next-state, address and SCCB request logic.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        saddr_d    = saddr_q;
        sdata_d    = sdata_q;
        busy_d     = busy_q;
        done_d     = done_q;
        fetch_d    = fetch_q;
        wfirst_d   = wfirst_q;
        tmr_load   = 1'b0;
        sccb_start = 1'b0;
        advance    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    fetch_d = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // One cycle for the address register, one for the ROM register.
                fetch_d = ~fetch_q;
                if (fetch_q) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (i_rom_data == CFG_END_WORD) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (i_rom_data == CFG_DELAY_WORD) begin
                    tmr_load = 1'b1;
                    state_d  = ST_DELAY;
                end else begin
                    saddr_d = i_rom_data[15:8];
                    sdata_d = i_rom_data[7:0];
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (i_sccb_ready) begin
                    sccb_start = 1'b1;
                    wfirst_d   = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The master lowers ready a cycle after accepting, so the
                // first WAIT cycle still shows the stale ready.
                wfirst_d = 1'b0;
                if (!wfirst_q && i_sccb_ready) begin
                    advance = 1'b1;
                end
            end
            ST_DELAY: begin
                if (tmr_zero) begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Step to the next entry, stopping at the top of the address space.
        if (advance) begin
            if (addr_q == ADDR_LAST) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end else begin
                addr_d  = addr_q + 1'b1;
                fetch_d = 1'b0;
                state_d = ST_FETCH;
            end
        end
    end

    // State and datapath registers; reset aborts any sequence in flight.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            saddr_q  <= '0;
            sdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fetch_q  <= 1'b0;
            wfirst_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            saddr_q  <= saddr_d;
            sdata_q  <= sdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fetch_q  <= fetch_d;
            wfirst_q <= wfirst_d;
        end
    end

    assign o_rom_addr   = addr_q;
    assign o_sccb_start = sccb_start;
    assign o_sccb_addr  = saddr_q;
    assign o_sccb_data  = sdata_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule
